// File: rtl/dual_mc_pkg.sv
// Shared definitions for the dual micro-controller slice: opcodes, operand selectors,
// instruction field positions and result fitting. SATURATE_EN selects clamping instead of wrapping.
package dual_mc_pkg;

  localparam int INSTR_W = 20;
  localparam int OP_HI   = 19;
  localparam int OP_LO   = 16;
  localparam int SRC_HI  = 15;
  localparam int SRC_LO  = 14;
  localparam int DST_HI  = 13;
  localparam int DST_LO  = 12;
  localparam int RSVD_BIT = 11;
  localparam int IMM_HI  = 10;
  localparam int IMM_LO  = 0;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_TEQ = 4'd6;
  localparam logic [3:0] OP_TGT = 4'd7;
  localparam logic [3:0] OP_SLP = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;

  typedef enum logic [1:0] {SRC_IMM, SRC_ACC, SRC_P0, SRC_P1} src_e;
  typedef enum logic [1:0] {DST_NONE, DST_ACC, DST_P0, DST_P1} dst_e;

  localparam int MAX_VAL  = 999;
  localparam int MIN_VAL  = -999;
  localparam int NOT_TRUE = 100;

  // Arithmetic is done at this width so an 11x11 product never overflows before fitting.
  localparam int FULL_W = 22;
  localparam logic signed [FULL_W-1:0] MAX_FULL = FULL_W'(MAX_VAL);
  localparam logic signed [FULL_W-1:0] MIN_FULL = FULL_W'(MIN_VAL);

`ifdef SATURATE_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  // Clamp when saturation is built in; otherwise the caller's truncation wraps.
  function automatic logic signed [FULL_W-1:0] fit_result(input logic signed [FULL_W-1:0] v);
    logic signed [FULL_W-1:0] r;
    r = v;
    if (SAT_ON && (v > MAX_FULL)) r = MAX_FULL;
    else if (SAT_ON && (v < MIN_FULL)) r = MIN_FULL;
    return r;
  endfunction

endpackage

// File: rtl/dual_mc_design_core.sv
// One micro-controller core (mc_core) and its read-only program store (mc_imem).
// The program store is preloaded from outside through dutN.instructionMemory.memory.
module mc_imem
  import dual_mc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic [AW-1:0]      addr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] memory [0:DEPTH-1];

  assign rdata = memory[addr];

endmodule

module mc_core
  import dual_mc_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int DATA_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              posedge_big_clk,
  input  logic [DATA_W-1:0] p0_in,
  input  logic [DATA_W-1:0] p1_in,
  output logic [DATA_W-1:0] p0_out,
  output logic [DATA_W-1:0] p1_out
);

  localparam int PC_W = $clog2(PROG_DEPTH);

  logic [PC_W-1:0]           program_counter;
  logic [PC_W-1:0]           pc_nxt;
  logic [PC_W-1:0]           pc_plus1;
  logic [PC_W-1:0]           pc_plus2;
  logic [PC_W:0]             pc_p1_w;
  logic [PC_W:0]             pc_p2_w;
  logic [INSTR_W-1:0]        final_instruction;
  logic [3:0]                opcode;
  src_e                      src_sel;
  dst_e                      dst_sel;
  logic                      rsvd_unused;
  logic signed [DATA_W-1:0]  imm;
  logic signed [DATA_W-1:0]  src_val;
  logic signed [DATA_W-1:0]  acc;
  logic signed [DATA_W-1:0]  acc_nxt;
  logic [DATA_W-1:0]         p0_nxt;
  logic [DATA_W-1:0]         p1_nxt;
  logic signed [FULL_W-1:0]  acc_x;
  logic signed [FULL_W-1:0]  src_x;
  logic signed [FULL_W-1:0]  alu_full;
  logic signed [FULL_W-1:0]  mov_full;

  mc_imem #(.DEPTH(PROG_DEPTH), .AW(PC_W)) instructionMemory (
    .addr  (program_counter),
    .rdata (final_instruction)
  );

  assign opcode      = final_instruction[OP_HI:OP_LO];
  assign src_sel     = src_e'(final_instruction[SRC_HI:SRC_LO]);
  assign dst_sel     = dst_e'(final_instruction[DST_HI:DST_LO]);
  assign rsvd_unused = final_instruction[RSVD_BIT];
  assign imm         = DATA_W'($signed(final_instruction[IMM_HI:IMM_LO]));

  always_comb begin
    src_val = imm;
    case (src_sel)
      SRC_ACC: src_val = acc;
      SRC_P0:  src_val = p0_in;
      SRC_P1:  src_val = p1_in;
      default: src_val = imm;
    endcase
  end

  assign acc_x = FULL_W'(acc);
  assign src_x = FULL_W'(src_val);

  always_comb begin
    case (opcode)
      OP_ADD:  alu_full = acc_x + src_x;
      OP_SUB:  alu_full = acc_x - src_x;
      default: alu_full = acc_x * src_x;
    endcase
  end

  // Only immediates are fitted on MOV; register and port values pass through as-is.
  assign mov_full = (src_sel == SRC_IMM) ? fit_result(src_x) : src_x;

  // PC arithmetic one bit wider so wrap works for any program depth.
  assign pc_p1_w  = {1'b0, program_counter} + (PC_W+1)'(1);
  assign pc_p2_w  = {1'b0, program_counter} + (PC_W+1)'(2);
  assign pc_plus1 = (pc_p1_w >= (PC_W+1)'(PROG_DEPTH)) ?
                    PC_W'(pc_p1_w - (PC_W+1)'(PROG_DEPTH)) : pc_p1_w[PC_W-1:0];
  assign pc_plus2 = (pc_p2_w >= (PC_W+1)'(PROG_DEPTH)) ?
                    PC_W'(pc_p2_w - (PC_W+1)'(PROG_DEPTH)) : pc_p2_w[PC_W-1:0];

  always_comb begin
    acc_nxt = acc;
    p0_nxt  = p0_out;
    p1_nxt  = p1_out;
    pc_nxt  = pc_plus1;
    case (opcode)
      OP_NOP: ;
      OP_MOV: begin
        case (dst_sel)
          DST_ACC: acc_nxt = DATA_W'(mov_full);
          DST_P0:  p0_nxt  = DATA_W'(mov_full);
          DST_P1:  p1_nxt  = DATA_W'(mov_full);
          default: ;
        endcase
      end
      OP_ADD, OP_SUB, OP_MUL: acc_nxt = DATA_W'(fit_result(alu_full));
      OP_NOT: acc_nxt = (acc == '0) ? DATA_W'(NOT_TRUE) : '0;
      OP_TEQ: if (acc != src_val) pc_nxt = pc_plus2;
      OP_TGT: if (!(acc > src_val)) pc_nxt = pc_plus2;
      // A sleeping core simply re-presents SLP until the time-unit strobe arrives.
      OP_SLP: if (!posedge_big_clk) pc_nxt = program_counter;
      OP_JMP: pc_nxt = imm[PC_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      program_counter <= '0;
      acc             <= '0;
      p0_out          <= '0;
      p1_out          <= '0;
    end else begin
      program_counter <= pc_nxt;
      acc             <= acc_nxt;
      p0_out          <= p0_nxt;
      p1_out          <= p1_nxt;
    end
  end

endmodule

// File: rtl/dual_mc_design.sv
// Two chained mc_core instances: dut0 takes input_signal, dut1 drives output_signal.
// Build with SATURATE_EN defined to clamp arithmetic results to +/-999.
module dual_mc_design
  import dual_mc_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int DATA_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              posedge_big_clk,
  input  logic [DATA_W-1:0] input_signal,
  output logic [DATA_W-1:0] output_signal
);

  logic [DATA_W-1:0] d0_p1_out;
  logic [DATA_W-1:0] d1_p0_out;
  logic [DATA_W-1:0] d0_p0_out_unused;

  // Cross-core links are registered outputs, so the chain has no combinational loop.
  mc_core #(.PROG_DEPTH(PROG_DEPTH), .DATA_W(DATA_W)) dut0 (
    .clk             (clk),
    .reset           (reset),
    .posedge_big_clk (posedge_big_clk),
    .p0_in           (input_signal),
    .p1_in           (d1_p0_out),
    .p0_out          (d0_p0_out_unused),
    .p1_out          (d0_p1_out)
  );

  mc_core #(.PROG_DEPTH(PROG_DEPTH), .DATA_W(DATA_W)) dut1 (
    .clk             (clk),
    .reset           (reset),
    .posedge_big_clk (posedge_big_clk),
    .p0_in           (d0_p1_out),
    .p1_in           ('0),
    .p0_out          (d1_p0_out),
    .p1_out          (output_signal)
  );

endmodule

// File: tb/tb_dual_mc_design.sv
// Directed bench for dual_mc_design: programs are written into both cores' program stores,
// expected outputs are queued when stimulus is set up and compared when the cycle arrives.
module tb_dual_mc_design;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_TEQ = 4'd6;
  localparam logic [3:0] OP_TGT = 4'd7;
  localparam logic [3:0] OP_SLP = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [1:0] S_IMM = 2'd0, S_ACC = 2'd1, S_P0 = 2'd2;
  localparam logic [1:0] D_NONE = 2'd0, D_ACC = 2'd1, D_P1 = 2'd3;

  logic        clk;
  logic        reset;
  logic        posedge_big_clk;
  logic [10:0] input_signal;
  logic [10:0] output_signal;

  logic signed [10:0] exp_q[$];
  int n_checks;
  int n_pass;
  int m_pc;
  logic [19:0] prog[16];

  dual_mc_design dut (
    .clk             (clk),
    .reset           (reset),
    .posedge_big_clk (posedge_big_clk),
    .input_signal    (input_signal),
    .output_signal   (output_signal)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] enc(input logic [3:0] op, input logic [1:0] src,
                                      input logic [1:0] dst, input int imm);
    logic [10:0] imm_f;
    imm_f = imm[10:0];
    return {op, src, dst, 1'b0, imm_f};
  endfunction

  function automatic int fit(input int v);
`ifdef SATURATE_EN
    if (v > 999) return 999;
    if (v < -999) return -999;
    return v;
`else
    logic signed [10:0] t;
    t = v[10:0];
    return int'(t);
`endif
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_progs();
    for (int i = 0; i < 16; i++) begin
      dut.dut0.instructionMemory.memory[i] = '0;
      dut.dut1.instructionMemory.memory[i] = '0;
    end
  endtask

  task automatic load0(input int a, input logic [19:0] w);
    dut.dut0.instructionMemory.memory[a] = w;
  endtask

  task automatic load1(input int a, input logic [19:0] w);
    dut.dut1.instructionMemory.memory[a] = w;
  endtask

  // Called at a negedge with reset high: one edge in reset, then release.
  task automatic release_reset();
    tick();
    reset = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back(11'(v));
  endtask

  task automatic pop_check(input string tag);
    logic signed [10:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, $signed(output_signal));
    end else begin
      e = exp_q.pop_front();
      check(tag, $signed(output_signal), e);
    end
  endtask

  initial begin
    logic signed [31:0] tbl_acc[5];
    logic [3:0]         tbl_op[5];
    logic signed [31:0] tbl_imm[5];
    bit                 taken;

    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    posedge_big_clk = 1'b0;
    input_signal = '0;
    clear_progs();
    tick();
    tick();
    check("rst_pc0", dut.dut0.program_counter, 0);
    check("rst_pc1", dut.dut1.program_counter, 0);
    check("rst_out", $signed(output_signal), 0);

    // Running program, then asynchronous reset between clock edges
    load1(0, enc(OP_MOV, S_IMM, D_ACC, 42));
    load1(1, enc(OP_MOV, S_ACC, D_P1, 0));
    load1(2, enc(OP_JMP, S_IMM, D_NONE, 1));
    release_reset();
    push_exp(42);
    repeat (5) tick();
    pop_check("t1_out");
    check("t1_pc0_run", dut.dut0.program_counter, 5);
    #2 reset = 1'b1;
    #1;
    check("t1_async_pc0", dut.dut0.program_counter, 0);
    check("t1_async_pc1", dut.dut1.program_counter, 0);
    check("t1_async_acc1", $signed(dut.dut1.acc), 0);
    check("t1_async_out", $signed(output_signal), 0);

    // Forwarding chain with SLP: dut1 copies dut0's previous-cycle output
    tick();
    clear_progs();
    load0(0, enc(OP_MOV, S_P0, D_P1, 0));
    load0(1, enc(OP_SLP, S_IMM, D_NONE, 0));
    load1(0, enc(OP_MOV, S_P0, D_P1, 0));
    load1(1, enc(OP_SLP, S_IMM, D_NONE, 0));
    input_signal = 11'(123);
    release_reset();
    tick();
    check("t2_pc0_e1", dut.dut0.program_counter, 1);
    check("t2_pc1_e1", dut.dut1.program_counter, 1);
    check("t2_out_e1", $signed(output_signal), 0);
    repeat (3) tick();
    check("t2_pc0_stall", dut.dut0.program_counter, 1);
    check("t2_pc1_stall", dut.dut1.program_counter, 1);
    posedge_big_clk = 1'b1;
    tick();
    posedge_big_clk = 1'b0;
    check("t2_pc0_wake", dut.dut0.program_counter, 2);
    check("t2_pc1_wake", dut.dut1.program_counter, 2);
    push_exp(123);
    repeat (14) tick();
    check("t2_out_prewrap", $signed(output_signal), 0);
    tick();
    pop_check("t2_out");
    check("t2_pc1_resleep", dut.dut1.program_counter, 1);

    // ADD overflow
    reset = 1'b1;
    clear_progs();
    load1(0, enc(OP_MOV, S_IMM, D_ACC, 500));
    load1(1, enc(OP_ADD, S_IMM, D_NONE, 600));
    load1(2, enc(OP_MOV, S_ACC, D_P1, 0));
    load1(3, enc(OP_SLP, S_IMM, D_NONE, 0));
    push_exp(fit(1100));
    release_reset();
    repeat (3) tick();
    pop_check("t3_add");
    tick();
    check("t3_pc1_slp", dut.dut1.program_counter, 3);

    // MOV immediate fitting and MUL overflow
    reset = 1'b1;
    clear_progs();
    load1(0, enc(OP_MOV, S_IMM, D_P1, -1000));
    load1(1, enc(OP_MOV, S_IMM, D_ACC, -30));
    load1(2, enc(OP_MUL, S_IMM, D_NONE, 40));
    load1(3, enc(OP_MOV, S_ACC, D_P1, 0));
    load1(4, enc(OP_SLP, S_IMM, D_NONE, 0));
    push_exp(fit(-1000));
    push_exp(fit(-1200));
    release_reset();
    tick();
    pop_check("t3_mov_imm");
    repeat (3) tick();
    pop_check("t3_mul");

    // SUB from the neighbour's port, then NOT of non-zero and of zero
    reset = 1'b1;
    clear_progs();
    load0(0, enc(OP_MOV, S_P0, D_P1, 0));
    load0(1, enc(OP_SLP, S_IMM, D_NONE, 0));
    load1(0, enc(OP_MOV, S_IMM, D_ACC, 50));
    load1(1, enc(OP_SUB, S_P0, D_NONE, 0));
    load1(2, enc(OP_MOV, S_ACC, D_P1, 0));
    load1(3, enc(OP_NOT, S_IMM, D_NONE, 0));
    load1(4, enc(OP_MOV, S_ACC, D_P1, 0));
    load1(5, enc(OP_NOT, S_IMM, D_NONE, 0));
    load1(6, enc(OP_MOV, S_ACC, D_P1, 0));
    load1(7, enc(OP_SLP, S_IMM, D_NONE, 0));
    input_signal = 11'(-7);
    push_exp(fit(50 + 7));
    push_exp(0);
    push_exp(100);
    release_reset();
    repeat (3) tick();
    pop_check("t3_sub_p0");
    repeat (2) tick();
    pop_check("t3_not_nz");
    repeat (2) tick();
    pop_check("t3_not_z");

    // Conditional skips: {acc, op, imm}
    tbl_acc[0] = 5;  tbl_op[0] = OP_TEQ; tbl_imm[0] = 5;
    tbl_acc[1] = 5;  tbl_op[1] = OP_TEQ; tbl_imm[1] = 6;
    tbl_acc[2] = 5;  tbl_op[2] = OP_TGT; tbl_imm[2] = 4;
    tbl_acc[3] = 5;  tbl_op[3] = OP_TGT; tbl_imm[3] = 5;
    tbl_acc[4] = -5; tbl_op[4] = OP_TGT; tbl_imm[4] = 3;
    for (int t = 0; t < 5; t++) begin
      reset = 1'b1;
      clear_progs();
      load1(0, enc(OP_MOV, S_IMM, D_ACC, tbl_acc[t]));
      load1(1, enc(tbl_op[t], S_IMM, D_NONE, tbl_imm[t]));
      load1(2, enc(OP_MOV, S_IMM, D_P1, 1));
      load1(3, enc(OP_MOV, S_IMM, D_P1, 2));
      load1(4, enc(OP_SLP, S_IMM, D_NONE, 0));
      taken = (tbl_op[t] == OP_TEQ) ? (tbl_acc[t] == tbl_imm[t]) : (tbl_acc[t] > tbl_imm[t]);
      if (taken) push_exp(1);
      push_exp(2);
      release_reset();
      repeat (2) tick();
      check($sformatf("t4_pc_after_test%0d", t), dut.dut1.program_counter, taken ? 2 : 3);
      check($sformatf("t4_out_before%0d", t), $signed(output_signal), 0);
      if (taken) begin
        tick();
        pop_check($sformatf("t4_first%0d", t));
      end
      tick();
      pop_check($sformatf("t4_second%0d", t));
      tick();
      check($sformatf("t4_pc_slp%0d", t), dut.dut1.program_counter, 4);
    end

    // NOP sweep (including undefined opcodes) and PC wrap
    reset = 1'b1;
    clear_progs();
    for (int i = 0; i < 16; i++) begin
      prog[i] = enc((i % 2 == 0) ? OP_NOP : 4'(10 + (i % 6)), S_IMM, D_P1, i * 7);
      load0(i, prog[i]);
      load1(i, prog[i]);
    end
    release_reset();
    check("t5_pc_start", dut.dut0.program_counter, 0);
    check("t5_fi_start", dut.dut0.final_instruction, prog[0]);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("t5_pc_%0d", k), dut.dut0.program_counter, k % 16);
      check($sformatf("t5_fi_%0d", k), dut.dut0.final_instruction, prog[k % 16]);
    end
    check("t5_pc1_end", dut.dut1.program_counter, 1);
    check("t5_out_quiet", $signed(output_signal), 0);

    // SLP at word 0 with a strobe every 11 clocks
    reset = 1'b1;
    clear_progs();
    load0(0, enc(OP_SLP, S_IMM, D_NONE, 0));
    release_reset();
    m_pc = 0;
    for (int c = 0; c < 60; c++) begin
      posedge_big_clk = (c % 11 == 0);
      tick();
      if (m_pc == 0) m_pc = posedge_big_clk ? 1 : 0;
      else m_pc = (m_pc + 1) % 16;
      check($sformatf("t6_pc_c%0d", c), dut.dut0.program_counter, m_pc);
    end
    posedge_big_clk = 1'b0;

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
